// File: rtl/vae_fixed_pkg.sv
// vae_fixed_pkg: shared fixed-point defaults, FSM states and saturation helper for the VAE datapath
package vae_fixed_pkg;
    localparam int DEF_BITSIZE = 16;
    localparam int DEF_FRAC    = 8;

    typedef enum logic [1:0] {IDLE, MAC, BIAS, DONE} state_t;

    localparam logic signed [DEF_BITSIZE-1:0] SAT_MAX = {1'b0, {(DEF_BITSIZE-1){1'b1}}};
    localparam logic signed [DEF_BITSIZE-1:0] SAT_MIN = {1'b1, {(DEF_BITSIZE-1){1'b0}}};

    // Clamp a wide signed value into a signed range of the given word width
    function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int bits);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction
endpackage

// File: rtl/enc_mac_unit.sv
// enc_mac_unit: the block's single multiplier feeding a clearable signed accumulator
module enc_mac_unit #(
    parameter int W  = 16,
    parameter int AW = 36
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic                 i_clr,
    input  logic signed [W-1:0]  i_a,
    input  logic signed [W-1:0]  i_b,
    output logic signed [AW-1:0] o_acc
);
    logic signed [2*W-1:0] w_prod;

    assign w_prod = i_a * i_b;

    // Accumulate the sign-extended full-width product; clear wins over enable
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            o_acc <= '0;
        else if (i_clr)
            o_acc <= '0;
        else if (i_en)
            o_acc <= o_acc + {{(AW-2*W){w_prod[2*W-1]}}, w_prod};
    end
endmodule

// File: rtl/encoder_fixed_point_mac.sv
// encoder_fixed_point_mac: latent encoder layer z[j] = sat(sum_i x[i]*w[j][i] + b[j]) on one shared MAC
module encoder_fixed_point_mac
    import vae_fixed_pkg::*;
#(
    parameter int M_input  = 9,
    parameter int N_latent = 2,
    parameter int BITSIZE  = DEF_BITSIZE,
    parameter int FRAC     = DEF_FRAC
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [M_input*BITSIZE-1:0]          x,
    input  logic [M_input*N_latent*BITSIZE-1:0] w,
    input  logic [N_latent*BITSIZE-1:0]         b,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [N_latent*BITSIZE-1:0]    out,
    output logic                           out_valid,
    input  logic                           out_ready
);
    localparam int ACC_W = 2*BITSIZE + $clog2(M_input);
    localparam int IW    = $clog2(M_input);
    localparam int JW    = (N_latent > 1) ? $clog2(N_latent) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(M_input - 1);
    localparam logic [JW-1:0] J_LAST = JW'(N_latent - 1);

    state_t                              r_state;
    logic [IW-1:0]                       r_i;
    logic [JW-1:0]                       r_j;
    logic [M_input*BITSIZE-1:0]          r_x;
    logic [M_input*N_latent*BITSIZE-1:0] r_w;
    logic [N_latent*BITSIZE-1:0]         r_b;
    logic [N_latent*BITSIZE-1:0]         r_out;
    logic                                r_out_valid;

    logic                     w_accept;
    logic                     w_mac_en;
    logic                     w_mac_clr;
    logic signed [BITSIZE-1:0] w_xi;
    logic signed [BITSIZE-1:0] w_wji;
    logic signed [BITSIZE-1:0] w_bj;
    logic signed [ACC_W-1:0]  w_acc;
    logic signed [ACC_W:0]    w_r;
    logic signed [63:0]       w_r64;
    logic [BITSIZE-1:0]       w_z;

    assign in_ready  = (r_state == IDLE);
    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign w_accept  = in_valid && (r_state == IDLE);
    assign w_mac_en  = (r_state == MAC);
    // Start every latent output from a zero accumulator: on accept and between outputs
    assign w_mac_clr = w_accept || ((r_state == BIAS) && (r_j != J_LAST));

    assign w_xi  = r_x[int'(r_i)*BITSIZE +: BITSIZE];
    assign w_wji = r_w[(int'(r_j)*M_input + int'(r_i))*BITSIZE +: BITSIZE];
    assign w_bj  = r_b[int'(r_j)*BITSIZE +: BITSIZE];

    // Floor-truncate the Q product sum back to the word's scale, add bias one bit wider, then clamp
    assign w_r   = {w_acc[ACC_W-1], w_acc >>> FRAC} + {{(ACC_W+1-BITSIZE){w_bj[BITSIZE-1]}}, w_bj};
    assign w_r64 = {{(63-ACC_W){w_r[ACC_W]}}, w_r};
    assign w_z   = BITSIZE'(sat(w_r64, BITSIZE));

    enc_mac_unit #(
        .W  (BITSIZE),
        .AW (ACC_W)
    ) u_mac (
        .i_clk (clk),
        .i_rst (reset),
        .i_en  (w_mac_en),
        .i_clr (w_mac_clr),
        .i_a   (w_xi),
        .i_b   (w_wji),
        .o_acc (w_acc)
    );

    // Sequencer: latch a job, sweep i for each j, write z[j] in BIAS, hold the result in DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_i         <= '0;
            r_j         <= '0;
            r_x         <= '0;
            r_w         <= '0;
            r_b         <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_x     <= x;
                    r_w     <= w;
                    r_b     <= b;
                    r_i     <= '0;
                    r_j     <= '0;
                    r_state <= MAC;
                end
                MAC: begin
                    r_i <= r_i + 1'b1;
                    if (r_i == I_LAST)
                        r_state <= BIAS;
                end
                BIAS: begin
                    r_out[int'(r_j)*BITSIZE +: BITSIZE] <= w_z;
                    r_i <= '0;
                    if (r_j == J_LAST) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_j     <= r_j + 1'b1;
                        r_state <= MAC;
                    end
                end
                DONE: if (out_ready) begin
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_encoder_fixed_point_mac.sv
// tb_encoder_fixed_point_mac: directed and randomized checks of the latent encoder against an arithmetic model
module tb_encoder_fixed_point_mac;
    localparam int M = 9;
    localparam int N = 2;
    localparam int XW = M*16;
    localparam int WW = M*N*16;
    localparam int OW = N*16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [XW-1:0] x = '0;
    logic [WW-1:0] w = '0;
    logic [OW-1:0] b = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [OW-1:0] out;
    logic          out_valid;
    logic          out_ready = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    encoder_fixed_point_mac dut (
        .clk       (clk),
        .reset     (reset),
        .x         (x),
        .w         (w),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [OW-1:0] model(input logic [XW-1:0] xv, input logic [WW-1:0] wv, input logic [OW-1:0] bv);
        logic [OW-1:0] z;
        longint acc;
        longint r;
        z = '0;
        for (int j = 0; j < N; j++) begin
            acc = 0;
            for (int i = 0; i < M; i++)
                acc += longint'($signed(xv[i*16 +: 16])) * longint'($signed(wv[(j*M+i)*16 +: 16]));
            r = (acc >>> 8) + longint'($signed(bv[j*16 +: 16]));
            if (r > 32767) r = 32767;
            if (r < -32768) r = -32768;
            z[j*16 +: 16] = r[15:0];
        end
        return z;
    endfunction

    task automatic gen(output logic [XW-1:0] xv, output logic [WW-1:0] wv, output logic [OW-1:0] bv, input bit full);
        for (int i = 0; i < M; i++)
            xv[i*16 +: 16] = full ? 16'($urandom) : 16'($urandom_range(0, 1023)) - 16'd512;
        for (int i = 0; i < M*N; i++)
            wv[i*16 +: 16] = full ? 16'($urandom) : 16'($urandom_range(0, 1023)) - 16'd512;
        for (int j = 0; j < N; j++)
            bv[j*16 +: 16] = 16'($urandom);
    endtask

    task automatic start(input logic [XW-1:0] xv, input logic [WW-1:0] wv, input logic [OW-1:0] bv, input string tag);
        @(negedge clk);
        x = xv; w = wv; b = bv; in_valid = 1'b1;
        chk($sformatf("%s_ready", tag), in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk($sformatf("%s_busy", tag), in_ready, 0);
    endtask

    task automatic run_job(input logic [XW-1:0] xv, input logic [WW-1:0] wv, input logic [OW-1:0] bv,
                           input logic [OW-1:0] exp, input string tag, input int hold);
        int cyc;
        logic [OW-1:0] saved;
        logic [XW-1:0] nx;
        logic [WW-1:0] nw;
        logic [OW-1:0] nb;
        start(xv, wv, bv, tag);
        x = ~xv;
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("%s_latency", tag), cyc, 20);
        chk($sformatf("%s_out", tag), out, exp);
        saved = out;
        for (int k = 0; k < hold; k++) begin
            gen(nx, nw, nb, 1'b1);
            x = nx; w = nw; b = nb; in_valid = ~in_valid;
            @(negedge clk);
            chk($sformatf("%s_hold_out%0d", tag, k), out, saved);
            chk($sformatf("%s_hold_valid%0d", tag, k), out_valid, 1);
            chk($sformatf("%s_hold_ready%0d", tag, k), in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk($sformatf("%s_post_valid", tag), out_valid, 0);
        chk($sformatf("%s_post_ready", tag), in_ready, 1);
        chk($sformatf("%s_post_keep", tag), out, saved);
    endtask

    initial begin
        logic [XW-1:0] xv;
        logic [WW-1:0] wv;
        logic [OW-1:0] bv;
        repeat (2) @(negedge clk);
        chk("rst_out", out, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        reset = 1'b0;

        run_job({M{16'h0100}}, {(M*N){16'h0080}}, 32'h0000_0000, 32'h0480_0480, "basic", 0);
        run_job({M{16'hFF00}}, {(M*N){16'h0100}}, 32'hFF80_0080, 32'hF680_F780, "signbias", 0);
        run_job({M{16'h7FFF}}, {(M*N){16'h7FFF}}, 32'h7FFF_7FFF, 32'h7FFF_7FFF, "sat_hi", 0);
        run_job({M{16'h7FFF}}, {(M*N){16'h8000}}, 32'h7FFF_7FFF, 32'h8000_8000, "sat_lo", 0);
        run_job({M{16'h0001}}, {(M*N){16'hFFFF}}, 32'h0000_0000, 32'hFFFF_FFFF, "trunc", 0);

        gen(xv, wv, bv, 1'b0);
        run_job(xv, wv, bv, model(xv, wv, bv), "backpressure", 5);
        gen(xv, wv, bv, 1'b0);
        run_job(xv, wv, bv, model(xv, wv, bv), "after_bp", 0);

        for (int t = 0; t < 6; t++) begin
            gen(xv, wv, bv, t[0]);
            run_job(xv, wv, bv, model(xv, wv, bv), $sformatf("rand%0d", t), 0);
        end

        start({M{16'h0200}}, {(M*N){16'h0100}}, 32'h0001_0001, "abort");
        repeat (7) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_out", out, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        run_job({M{16'h0100}}, {(M*N){16'h0080}}, 32'h0000_0000, 32'h0480_0480, "fresh", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
